trace_capture_ctrl: RTL and testbench

TRACE_CAPTURE_CTRL -- requirements
Module: trace_capture_ctrl

---
 rtl/trace_capture_ctrl.sv | 124 ++++++++++++
 tb/tb_trace_capture_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_capture_ctrl.sv
// Trace capture controller: arm, wait for stream sync, trigger with optional delay,
// then write samples into the capture FIFO until the limit, an overflow, or an abort.
module trace_capture_ctrl #(
  parameter int pCNT_WIDTH = 16
) (
  input  logic                  trace_clk,
  input  logic                  reset,
  input  logic                  I_arm,
  input  logic                  I_abort,
  input  logic                  I_trig,
  input  logic                  I_synchronized,
  input  logic                  I_data_valid,
  input  logic                  I_fifo_full,
  input  logic [pCNT_WIDTH-1:0] I_max_samples,
  input  logic [pCNT_WIDTH-1:0] I_trig_delay,
  output logic                  O_armed,
  output logic                  O_capturing,
  output logic                  O_fifo_wr,
  output logic                  O_trig_out,
  output logic                  O_done,
  output logic                  O_overflow,
  output logic [pCNT_WIDTH-1:0] O_sample_count
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SYNC,
    ARMED,
    DELAY,
    CAPTURE,
    DONE
  } state_t;

  state_t state, next_state;

  logic                  arm_q;
  logic                  primed;
  logic                  arm_edge;
  logic                  wr;
  logic                  ovf_event;
  logic                  limit_hit;
  logic [pCNT_WIDTH:0]   count_inc;
  logic [pCNT_WIDTH-1:0] delay_cnt;
  logic                  next_armed;
  logic                  next_capturing;
  logic                  next_done;
  logic                  next_trig_out;

  // primed stays low for the first edge after reset so an I_arm already high is not an edge
  assign arm_edge  = I_arm & ~arm_q & primed;
  assign wr        = O_capturing & I_data_valid & ~I_fifo_full;
  assign ovf_event = O_capturing & I_data_valid & I_fifo_full;
  assign count_inc = {1'b0, O_sample_count} + (pCNT_WIDTH + 1)'(1);
  assign limit_hit = (I_max_samples != '0) && (count_inc >= {1'b0, I_max_samples});
  assign O_fifo_wr = wr;

  always_ff @(posedge trace_clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      O_armed     <= 1'b0;
      O_capturing <= 1'b0;
      O_done      <= 1'b0;
      O_trig_out  <= 1'b0;
    end else begin
      state       <= next_state;
      O_armed     <= next_armed;
      O_capturing <= next_capturing;
      O_done      <= next_done;
      O_trig_out  <= next_trig_out;
    end
  end

  always_comb begin
    next_state = state;
    if (I_abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:      if (arm_edge) next_state = I_synchronized ? ARMED : WAIT_SYNC;
        WAIT_SYNC: if (I_synchronized) next_state = ARMED;
        ARMED:     if (I_trig) next_state = (I_trig_delay == '0) ? CAPTURE : DELAY;
        DELAY:     if (delay_cnt <= (pCNT_WIDTH)'(1)) next_state = CAPTURE;
        CAPTURE:   if (ovf_event || (wr && limit_hit)) next_state = DONE;
        DONE:      if (!I_arm) next_state = IDLE;
        default:   next_state = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they come straight out of flops
  always_comb begin
    next_armed     = (next_state == WAIT_SYNC) || (next_state == ARMED) || (next_state == DELAY);
    next_capturing = (next_state == CAPTURE);
    next_done      = (next_state == DONE);
    next_trig_out  = (next_state == CAPTURE) && (state != CAPTURE);
  end

  always_ff @(posedge trace_clk or posedge reset) begin
    if (reset) begin
      arm_q          <= 1'b0;
      primed         <= 1'b0;
      delay_cnt      <= '0;
      O_sample_count <= '0;
      O_overflow     <= 1'b0;
    end else begin
      arm_q  <= I_arm;
      primed <= 1'b1;
      if (!I_abort && (state == ARMED) && I_trig) begin
        delay_cnt <= I_trig_delay;
      end else if ((state == DELAY) && (delay_cnt != '0)) begin
        delay_cnt <= delay_cnt - (pCNT_WIDTH)'(1);
      end
      // Abort leaves the count and overflow flag intact for software to read back
      if (!I_abort && (state == IDLE) && arm_edge) begin
        O_sample_count <= '0;
        O_overflow     <= 1'b0;
      end else begin
        if (wr && (O_sample_count != '1)) O_sample_count <= count_inc[pCNT_WIDTH-1:0];
        if (ovf_event) O_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Self-checking bench for trace_capture_ctrl; a narrow counter width keeps saturation reachable.
module tb_trace_capture_ctrl;
  localparam int CW = 4;

  logic          trace_clk = 1'b0;
  logic          reset = 1'b1;
  logic          I_arm = 1'b0;
  logic          I_abort = 1'b0;
  logic          I_trig = 1'b0;
  logic          I_synchronized = 1'b0;
  logic          I_data_valid = 1'b0;
  logic          I_fifo_full = 1'b0;
  logic [CW-1:0] I_max_samples = '0;
  logic [CW-1:0] I_trig_delay = '0;
  logic          O_armed, O_capturing, O_fifo_wr, O_trig_out, O_done, O_overflow;
  logic [CW-1:0] O_sample_count;

  int n_checks = 0;
  int n_fail = 0;

  trace_capture_ctrl #(.pCNT_WIDTH(CW)) dut (
    .trace_clk(trace_clk), .reset(reset), .I_arm(I_arm), .I_abort(I_abort),
    .I_trig(I_trig), .I_synchronized(I_synchronized), .I_data_valid(I_data_valid),
    .I_fifo_full(I_fifo_full), .I_max_samples(I_max_samples), .I_trig_delay(I_trig_delay),
    .O_armed(O_armed), .O_capturing(O_capturing), .O_fifo_wr(O_fifo_wr),
    .O_trig_out(O_trig_out), .O_done(O_done), .O_overflow(O_overflow),
    .O_sample_count(O_sample_count)
  );

  always #5 trace_clk = ~trace_clk;

  task automatic cyc();
    @(posedge trace_clk);
    #1;
  endtask

  // Leaves the DUT in the first cycle after the arm edge has been taken
  task automatic arm(input logic sync);
    I_synchronized = sync;
    I_arm = 1'b0;
    cyc();
    I_arm = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    logic [CW+5:0] got;
    I_arm = 1'b1;
    I_data_valid = 1'b1;
    @(negedge trace_clk) reset = 1'b1;
    #1;
    got = {O_armed, O_capturing, O_fifo_wr, O_trig_out, O_done, O_overflow, O_sample_count};
    n_checks++;
    if (got !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", got);
    end
    @(negedge trace_clk) reset = 1'b0;
    cyc();
    cyc();
    #1;
    n_checks++;
    if (O_armed !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_arm_held_no_edge: got armed=%b expected 0", O_armed);
    end
    I_arm = 1'b0;
    I_data_valid = 1'b0;
    cyc();
  endtask

  task automatic test_basic();
    int writes = 0;
    int pulses = 0;
    I_trig_delay = '0;
    I_max_samples = CW'(4);
    I_data_valid = 1'b1;
    I_fifo_full = 1'b0;
    arm(1'b1);
    #1;
    n_checks++;
    if (O_armed !== 1'b1 || O_sample_count !== '0) begin
      n_fail++;
      $display("[TB] FAIL basic_armed: got armed=%b count=%0d expected armed=1 count=0", O_armed, O_sample_count);
    end
    I_trig = 1'b1;
    cyc();
    I_trig = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      #1;
      writes += int'(O_fifo_wr);
      pulses += int'(O_trig_out);
      if (k == 1) begin
        n_checks++;
        if (O_trig_out !== 1'b1 || O_capturing !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL basic_trig_out: got trig=%b capt=%b expected 1 1", O_trig_out, O_capturing);
        end
      end
      if (k == 5) begin
        n_checks++;
        if (O_done !== 1'b1 || O_sample_count !== CW'(4)) begin
          n_fail++;
          $display("[TB] FAIL basic_done: got done=%b count=%0d expected done=1 count=4", O_done, O_sample_count);
        end
      end
      cyc();
    end
    n_checks++;
    if (writes != 4 || pulses != 1) begin
      n_fail++;
      $display("[TB] FAIL basic_totals: got writes=%0d pulses=%0d expected 4 1", writes, pulses);
    end
    I_arm = 1'b0;
    cyc();
  endtask

  task automatic test_delay_retrigger();
    int pulses = 0;
    I_trig_delay = CW'(3);
    I_max_samples = CW'(2);
    I_data_valid = 1'b1;
    arm(1'b1);
    I_trig = 1'b1;
    cyc();
    for (int k = 1; k <= 6; k++) begin
      I_trig = (k == 2);
      #1;
      pulses += int'(O_trig_out);
      n_checks++;
      if (O_capturing !== (k == 4 || k == 5)) begin
        n_fail++;
        $display("[TB] FAIL delay_capturing k=%0d: got %b expected %b", k, O_capturing, (k == 4 || k == 5));
      end
      cyc();
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++;
      $display("[TB] FAIL delay_single_pulse: got %0d pulses expected 1", pulses);
    end
    I_trig = 1'b0;
    I_arm = 1'b0;
    cyc();
  endtask

  task automatic test_wait_sync();
    I_trig_delay = '0;
    I_max_samples = '0;
    I_data_valid = 1'b0;
    arm(1'b0);
    for (int w = 1; w <= 11; w++) begin
      I_trig = (w <= 10);
      I_synchronized = (w == 10);
      #1;
      n_checks++;
      if (O_armed !== 1'b1 || O_capturing !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL wait_sync w=%0d: got armed=%b capt=%b expected 1 0", w, O_armed, O_capturing);
      end
      if (w == 11) begin
        I_synchronized = 1'b0;
        I_trig = 1'b1;
      end
      cyc();
    end
    I_trig = 1'b0;
    #1;
    n_checks++;
    if (O_capturing !== 1'b1 || O_trig_out !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL sync_loss_trigger: got capt=%b trig=%b expected 1 1", O_capturing, O_trig_out);
    end
    I_abort = 1'b1;
    cyc();
    I_abort = 1'b0;
  endtask

  task automatic test_overflow();
    I_trig_delay = '0;
    I_max_samples = '0;
    I_data_valid = 1'b1;
    I_fifo_full = 1'b0;
    arm(1'b1);
    I_trig = 1'b1;
    cyc();
    I_trig = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      I_fifo_full = (k == 8);
      #1;
      n_checks++;
      if (O_fifo_wr !== (k <= 7)) begin
        n_fail++;
        $display("[TB] FAIL overflow_wr k=%0d: got %b expected %b", k, O_fifo_wr, (k <= 7));
      end
      cyc();
    end
    #1;
    n_checks++;
    if (O_done !== 1'b1 || O_overflow !== 1'b1 || O_sample_count !== CW'(7)) begin
      n_fail++;
      $display("[TB] FAIL overflow_end: got done=%b ovf=%b count=%0d expected 1 1 7", O_done, O_overflow, O_sample_count);
    end
    I_fifo_full = 1'b0;
  endtask

  task automatic test_done_hold();
    I_data_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++;
      if (O_done !== 1'b1 || O_overflow !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL done_hold k=%0d: got done=%b ovf=%b expected 1 1", k, O_done, O_overflow);
      end
      cyc();
    end
    I_arm = 1'b0;
    cyc();
    #1;
    n_checks++;
    if (O_done !== 1'b0 || O_armed !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL done_release: got done=%b armed=%b expected 0 0", O_done, O_armed);
    end
    I_arm = 1'b1;
    cyc();
    #1;
    n_checks++;
    if (O_armed !== 1'b1 || O_sample_count !== '0 || O_overflow !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL rearm_clear: got armed=%b count=%0d ovf=%b expected 1 0 0", O_armed, O_sample_count, O_overflow);
    end
    I_abort = 1'b1;
    cyc();
    I_abort = 1'b0;
  endtask

  task automatic test_saturate();
    int exp_cnt;
    I_trig_delay = '0;
    I_max_samples = '0;
    I_data_valid = 1'b1;
    arm(1'b1);
    I_trig = 1'b1;
    cyc();
    I_trig = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      exp_cnt = (k - 1 > 15) ? 15 : k - 1;
      #1;
      n_checks++;
      if (O_sample_count !== CW'(exp_cnt) || O_capturing !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL saturate k=%0d: got count=%0d capt=%b expected %0d 1", k, O_sample_count, O_capturing, exp_cnt);
      end
      cyc();
    end
    I_abort = 1'b1;
    cyc();
    I_abort = 1'b0;
  endtask

  task automatic test_abort();
    logic [CW+5:0] got;
    I_trig_delay = '0;
    I_max_samples = '0;
    I_data_valid = 1'b0;
    arm(1'b1);
    I_trig = 1'b1;
    I_abort = 1'b1;
    cyc();
    I_trig = 1'b0;
    I_abort = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_checks++;
      if (O_armed !== 1'b0 || O_capturing !== 1'b0 || O_trig_out !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL abort_vs_trig k=%0d: got armed=%b capt=%b trig=%b expected 0 0 0", k, O_armed, O_capturing, O_trig_out);
      end
      cyc();
    end
    I_data_valid = 1'b1;
    arm(1'b1);
    I_trig = 1'b1;
    cyc();
    I_trig = 1'b0;
    cyc();
    cyc();
    cyc();
    I_data_valid = 1'b0;
    I_abort = 1'b1;
    cyc();
    I_abort = 1'b0;
    #1;
    n_checks++;
    if (O_capturing !== 1'b0 || O_sample_count !== CW'(3)) begin
      n_fail++;
      $display("[TB] FAIL abort_preserve: got capt=%b count=%0d expected 0 3", O_capturing, O_sample_count);
    end
    I_data_valid = 1'b1;
    arm(1'b1);
    I_trig = 1'b1;
    cyc();
    I_trig = 1'b0;
    cyc();
    @(negedge trace_clk) reset = 1'b1;
    #1;
    got = {O_armed, O_capturing, O_fifo_wr, O_trig_out, O_done, O_overflow, O_sample_count};
    n_checks++;
    if (got !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_capture: got %h expected 0", got);
    end
    @(negedge trace_clk) reset = 1'b0;
    I_arm = 1'b0;
    I_data_valid = 1'b0;
    cyc();
  endtask

  // Reference: capture opens 1+D cycles after the trigger and closes the cycle after the M-th write
  task automatic test_random();
    int d, m, s, writes, done_at;
    logic valid;
    logic [4:0] exp_v, got_v;
    I_fifo_full = 1'b0;
    for (int it = 0; it < 8; it++) begin
      d = int'($urandom_range(0, 5));
      m = int'($urandom_range(1, 6));
      s = 1 + d;
      writes = 0;
      done_at = -1;
      I_data_valid = 1'b0;
      arm(1'b1);
      I_trig = 1'b1;
      I_trig_delay = CW'(d);
      I_max_samples = CW'(m);
      cyc();
      for (int c = 1; c <= s + 30; c++) begin
        valid = ($urandom_range(0, 99) < 70);
        I_data_valid = valid;
        I_trig = ($urandom_range(0, 1) == 1);
        I_trig_delay = CW'($urandom);
        #1;
        exp_v[4] = (c >= s) && (done_at < 0 || c < done_at);
        exp_v[3] = exp_v[4] && valid;
        exp_v[2] = (c == s);
        exp_v[1] = (done_at >= 0) && (c >= done_at);
        exp_v[0] = (c < s);
        got_v = {O_capturing, O_fifo_wr, O_trig_out, O_done, O_armed};
        n_checks++;
        if (got_v !== exp_v || O_sample_count !== CW'(writes)) begin
          n_fail++;
          $display("[TB] FAIL random it=%0d c=%0d d=%0d m=%0d: got capt/wr/trig/done/armed=%b count=%0d expected %b count=%0d",
                   it, c, d, m, got_v, O_sample_count, exp_v, writes);
        end
        if (exp_v[3]) begin
          writes++;
          if (writes == m) done_at = c + 1;
        end
        cyc();
      end
      I_trig = 1'b0;
      I_abort = 1'b1;
      I_arm = 1'b0;
      cyc();
      I_abort = 1'b0;
      #1;
      n_checks++;
      if (O_armed !== 1'b0 || O_capturing !== 1'b0 || O_done !== 1'b0 || O_sample_count !== CW'(writes)) begin
        n_fail++;
        $display("[TB] FAIL random_exit it=%0d: got armed=%b capt=%b done=%b count=%0d expected 0 0 0 %0d",
                 it, O_armed, O_capturing, O_done, O_sample_count, writes);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_delay_retrigger();
    test_wait_sync();
    test_overflow();
    test_done_hold();
    test_saturate();
    test_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
